// File: rtl/mux_rr_scheduler.sv
// Round-robin burst scheduler: muxes NUM_DATA requesters onto one registered output lane.
// Latency: one cycle from an accepted request to OUT_VALID/OUT_DATA/OUT_SEL.
// Backpressure: REQ_READY drops while a held word waits on OUT_READY; a stalled burst pauses, never ends.
module mux_rr_scheduler #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_DATA   = 16,
  parameter  int BURST_LEN  = 4,
  localparam int CTRL_WIDTH = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic [NUM_DATA-1:0]            REQ_VALID,
  input  logic [DATA_WIDTH*NUM_DATA-1:0] REQ_DATA,
  output logic [NUM_DATA-1:0]            REQ_READY,
  output logic                           OUT_VALID,
  output logic [DATA_WIDTH-1:0]          OUT_DATA,
  output logic [CTRL_WIDTH-1:0]          OUT_SEL,
  input  logic                           OUT_READY
);

  // Counter must hold BURST_LEN itself so the "burst complete" compare is exact.
  localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                state_q;
  logic [CTRL_WIDTH-1:0] ptr_q;
  logic [CTRL_WIDTH-1:0] ptr_d;
  logic [CTRL_WIDTH-1:0] grant_q;
  logic [CNT_WIDTH-1:0]  burst_cnt_q;
  logic [CNT_WIDTH-1:0]  burst_cnt_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CTRL_WIDTH-1:0] out_sel_q;

  logic                  arb_found;
  logic [CTRL_WIDTH-1:0] arb_idx;
  logic [CTRL_WIDTH:0]   scan_idx;
  logic                  grant_vld;
  logic [CTRL_WIDTH-1:0] grant_idx;
  logic                  accept_ok;
  logic                  xfer;
  logic                  burst_done;
  logic [DATA_WIDTH-1:0] sel_word;

  // Round-robin search: first valid requester at or above ptr_q, wrapping at NUM_DATA (not 2**CTRL_WIDTH).
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_DATA; k++) begin
      scan_idx = {1'b0, ptr_q} + (CTRL_WIDTH+1)'(k);
      if (scan_idx >= (CTRL_WIDTH+1)'(NUM_DATA)) begin
        scan_idx = scan_idx - (CTRL_WIDTH+1)'(NUM_DATA);
      end
      if (!arb_found && REQ_VALID[scan_idx[CTRL_WIDTH-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx[CTRL_WIDTH-1:0];
      end
    end
  end

  // Grant selection, one-hot ready, AND-OR data mux and next pointer/count values.
  always_comb begin
    grant_vld   = (state_q == ST_BURST) || arb_found;
    grant_idx   = (state_q == ST_BURST) ? grant_q : arb_idx;
    accept_ok   = !out_valid_q || OUT_READY;
    REQ_READY   = '0;
    sel_word    = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      // RESET_N gating keeps ready low while reset is held even if requesters are valid.
      if (RESET_N && grant_vld && accept_ok && (grant_idx == CTRL_WIDTH'(i))) begin
        REQ_READY[i] = 1'b1;
      end
      sel_word = sel_word |
                 (REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_idx == CTRL_WIDTH'(i)}});
    end
    xfer        = |(REQ_READY & REQ_VALID);
    ptr_d       = (grant_idx == CTRL_WIDTH'(NUM_DATA - 1)) ? '0 : (grant_idx + CTRL_WIDTH'(1));
    burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
    burst_done  = (burst_cnt_d == CNT_WIDTH'(BURST_LEN));
  end

  // IDLE/BURST controller plus the registered output stage.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_word;
        out_sel_q   <= grant_idx;
      end else if (OUT_READY) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            if (BURST_LEN > 1) begin
              state_q     <= ST_BURST;
              grant_q     <= arb_idx;
              burst_cnt_q <= CNT_WIDTH'(1);
            end else begin
              ptr_q <= ptr_d;
            end
          end
        end
        ST_BURST: begin
          // Only evaluated when the output can accept: a stall freezes grant and count.
          if (accept_ok) begin
            if (!REQ_VALID[grant_q] || burst_done) begin
              state_q     <= ST_IDLE;
              ptr_q       <= ptr_d;
              burst_cnt_q <= '0;
            end else begin
              burst_cnt_q <= burst_cnt_d;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_SEL   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: two instances (4 requesters/burst 4, 5 requesters/burst 1).
// Each requester word is {tag, index, per-requester transfer count}, so order and mux selection are visible.
// Expected words are queued by the stimulus; per-instance monitors pop them on each output handshake.
module tb_mux_rr_scheduler;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  logic [3:0]  a_req_valid;
  logic [63:0] a_req_data;
  logic [3:0]  a_req_ready;
  logic        a_out_valid;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_sel;
  logic        a_out_ready;

  logic [4:0]  b_req_valid;
  logic [79:0] b_req_data;
  logic [4:0]  b_req_ready;
  logic        b_out_valid;
  logic [15:0] b_out_data;
  logic [2:0]  b_out_sel;
  logic        b_out_ready;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [7:0]  a_seq[4];
  logic [7:0]  b_seq[5];

  always #5 clk = ~clk;

  mux_rr_scheduler #(.DATA_WIDTH(16), .NUM_DATA(4), .BURST_LEN(4)) u_a (
    .CLK(clk), .RESET_N(rst_n),
    .REQ_VALID(a_req_valid), .REQ_DATA(a_req_data), .REQ_READY(a_req_ready),
    .OUT_VALID(a_out_valid), .OUT_DATA(a_out_data), .OUT_SEL(a_out_sel),
    .OUT_READY(a_out_ready)
  );

  mux_rr_scheduler #(.DATA_WIDTH(16), .NUM_DATA(5), .BURST_LEN(1)) u_b (
    .CLK(clk), .RESET_N(rst_n),
    .REQ_VALID(b_req_valid), .REQ_DATA(b_req_data), .REQ_READY(b_req_ready),
    .OUT_VALID(b_out_valid), .OUT_DATA(b_out_data), .OUT_SEL(b_out_sel),
    .OUT_READY(b_out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] wa(input int s, input int k);
    return {16'(s), 4'hA, 4'(s), 8'(k)};
  endfunction

  function automatic logic [31:0] wb(input int s, input int k);
    return {16'(s), 4'hB, 4'(s), 8'(k)};
  endfunction

  task automatic drive_data();
    for (int i = 0; i < 4; i++) a_req_data[i*16 +: 16] = {4'hA, 4'(i), a_seq[i]};
    for (int i = 0; i < 5; i++) b_req_data[i*16 +: 16] = {4'hB, 4'(i), b_seq[i]};
  endtask

  task tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int seq_of(input int which, input int idx);
    if (which == 0) return int'(a_seq[idx]);
    return int'(b_seq[idx]);
  endfunction

  task automatic wait_seq(input string name, input int which, input int idx, input int target);
    int n = 0;
    while (seq_of(which, idx) < target && n < 50) begin
      tick();
      n++;
    end
    chk(name, 32'(seq_of(which, idx)), 32'(target));
  endtask

  // Requester model: advance a requester's word after each accepted transfer.
  initial begin : tracker
    logic [3:0] xa;
    logic [4:0] xb;
    logic       rs;
    for (int i = 0; i < 4; i++) a_seq[i] = '0;
    for (int i = 0; i < 5; i++) b_seq[i] = '0;
    drive_data();
    forever begin
      @(negedge clk);
      #4;
      xa = a_req_valid & a_req_ready;
      xb = b_req_valid & b_req_ready;
      rs = rst_n;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) a_seq[i] = !rs ? 8'd0 : (xa[i] ? a_seq[i] + 8'd1 : a_seq[i]);
      for (int i = 0; i < 5; i++) b_seq[i] = !rs ? 8'd0 : (xb[i] ? b_seq[i] + 8'd1 : b_seq[i]);
      drive_data();
    end
  end

  // Output monitor, instance A.
  initial begin : mon_a
    forever begin
      @(negedge clk);
      if (rst_n && a_out_valid && a_out_ready) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_out extra word actual=%0h required=none", {16'(a_out_sel), a_out_data});
        end else begin
          chk("a_out", {16'(a_out_sel), a_out_data}, exp_a.pop_front());
        end
      end
    end
  end

  // Output monitor, instance B.
  initial begin : mon_b
    forever begin
      @(negedge clk);
      if (rst_n && b_out_valid && b_out_ready) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_out extra word actual=%0h required=none", {16'(b_out_sel), b_out_data});
        end else begin
          chk("b_out", {16'(b_out_sel), b_out_data}, exp_b.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_ready"}, 32'(a_req_ready), 32'd0);
    chk({tag, "_a_valid"}, 32'(a_out_valid), 32'd0);
    chk({tag, "_a_data"},  32'(a_out_data),  32'd0);
    chk({tag, "_a_sel"},   32'(a_out_sel),   32'd0);
    chk({tag, "_b_ready"}, 32'(b_req_ready), 32'd0);
    chk({tag, "_b_valid"}, 32'(b_out_valid), 32'd0);
    chk({tag, "_b_data"},  32'(b_out_data),  32'd0);
    chk({tag, "_b_sel"},   32'(b_out_sel),   32'd0);
  endtask

  // Reset with every requester valid: ready must stay low throughout.
  task automatic do_reset();
    #1;
    rst_n       = 1'b0;
    a_req_valid = 4'hF;
    b_req_valid = 5'h1F;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    #1;
    check_reset_outputs("rst");
    tick();
    tick();
    a_req_valid = '0;
    b_req_valid = '0;
    rst_n       = 1'b1;
  endtask

  initial begin : stim
    int n;
    a_req_valid = '0;
    b_req_valid = '0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;

    // All four valid, burst 4: 0,0,0,0,1,1,1,1,2,... back to back.
    do_reset();
    a_req_valid = 4'hF;
    for (int s = 0; s < 4; s++) for (int k = 0; k < 4; k++) exp_a.push_back(wa(s, k));
    n = 0;
    repeat (16) begin
      tick();
      if (a_out_valid) n++;
    end
    a_req_valid = '0;
    chk("a1_one_per_cycle", 32'(n), 32'd16);
    tick();
    tick();

    // Stall three cycles mid-burst; burst then finishes its remaining two words.
    do_reset();
    a_req_valid = 4'b0011;
    for (int k = 0; k < 4; k++) exp_a.push_back(wa(0, k));
    exp_a.push_back(wa(1, 0));
    tick();
    tick();
    a_out_ready = 1'b0;
    #1;
    chk("a2_stall_ready", 32'(a_req_ready), 32'd0);
    repeat (3) begin
      tick();
      chk("a2_hold_data",  32'(a_out_data),  32'hA001);
      chk("a2_hold_sel",   32'(a_out_sel),   32'd0);
      chk("a2_hold_valid", 32'(a_out_valid), 32'd1);
      chk("a2_hold_ready", 32'(a_req_ready), 32'd0);
    end
    a_out_ready = 1'b1;
    wait_seq("a2_next_req1", 0, 1, 1);
    a_req_valid = '0;
    tick();
    tick();

    // Requester 1 drops after two words; pointer moves to 2 so 3 wins over 0.
    do_reset();
    a_req_valid = 4'b1010;
    exp_a.push_back(wa(1, 0));
    exp_a.push_back(wa(1, 1));
    exp_a.push_back(wa(3, 0));
    tick();
    tick();
    a_req_valid = 4'b1001;
    tick();
    chk("a3_bubble_valid", 32'(a_out_valid), 32'd0);
    tick();
    chk("a3_next_valid", 32'(a_out_valid), 32'd1);
    chk("a3_next_sel",   32'(a_out_sel),   32'd3);
    a_req_valid = '0;
    tick();
    tick();

    // Reset mid-burst with a held word: output discarded, search restarts at 0.
    do_reset();
    a_req_valid = 4'b0010;
    exp_a.push_back(wa(1, 0));
    tick();
    tick();
    a_out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("a4_rst_valid", 32'(a_out_valid), 32'd0);
    chk("a4_rst_data",  32'(a_out_data),  32'd0);
    chk("a4_rst_sel",   32'(a_out_sel),   32'd0);
    a_req_valid = 4'hF;
    tick();
    chk("a4_rst_ready", 32'(a_req_ready), 32'd0);
    tick();
    rst_n       = 1'b1;
    a_out_ready = 1'b1;
    exp_a.push_back(wa(0, 0));
    wait_seq("a4_first_req0", 0, 0, 1);
    a_req_valid = '0;
    tick();
    tick();

    // Five requesters, burst 1: only requester 2 valid.
    do_reset();
    b_req_valid = 5'b00100;
    for (int k = 0; k < 3; k++) exp_b.push_back(wb(2, k));
    wait_seq("b1_req2_three", 1, 2, 3);
    b_req_valid = '0;
    tick();
    tick();

    // Serve 3 to put pointer at 4, then 4 and 0 valid: 4, wrap to 0, then 4 again.
    do_reset();
    b_req_valid = 5'b01000;
    exp_b.push_back(wb(3, 0));
    exp_b.push_back(wb(4, 0));
    exp_b.push_back(wb(0, 0));
    exp_b.push_back(wb(4, 1));
    wait_seq("b2_req3", 1, 3, 1);
    b_req_valid = 5'b10001;
    wait_seq("b2_req0", 1, 0, 1);
    wait_seq("b2_req4", 1, 4, 2);
    b_req_valid = '0;

    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk("drain_a", 32'(exp_a.size()), 32'd0);
    chk("drain_b", 32'(exp_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
